// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ==== ram_fifo_ctrl : first-word-fall-through FIFO sequencer over a 64x8 single-port RAM ====
// ==== Rev 1.0                                                                             ====
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_pend_q, rd_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              rd_go, wr_go;

  // A read is only issued when its result is guaranteed a free output slot
  // two cycles later; reads win the RAM port over writes.
  always_comb begin
    rd_go    = !rst && (count_q != '0) && !rd_pend_q && (!out_valid_q || out_ready);
    in_ready = !rst && (count_q != C_DEPTH) && !rd_go;
    wr_go    = in_valid && in_ready;
  end

  always_comb begin
    ram_we   = wr_go;
    ram_data = in_data;
    ram_addr = wr_go ? wr_ptr_q : rd_ptr_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_pend_d   = rd_go;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (wr_go) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_go) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({wr_go, rd_go})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // ram_q is valid in the cycle after issue; a load there always finds a free slot.
    if (rd_pend_q) begin
      out_data_d  = ram_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ==== tb_ram_fifo_ctrl : directed bench with queue-based reference model and RAM model ====
// ==== Rev 1.0                                                                          ====
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
  logic [6:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
    .count(count)
  );

  // 64x8 single-port RAM: address register captured on non-write cycles.
  logic [7:0] mem [64];
  logic [5:0] addr_reg = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        addr_reg      <= ram_addr;
  end
  assign ram_q = mem[addr_reg];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every byte accepted and not yet consumed, oldest first.
  logic [7:0] mq [$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      prev_hold = 1'b0;
    end else begin
      int gap;
      if (prev_hold) begin
        chk("hold_valid", {31'b0, out_valid}, 1);
        chk("hold_data", {24'b0, out_data}, {24'b0, prev_data});
      end
      if (out_valid) begin
        if (mq.size() == 0) chk("order_nonempty", 0, 1);
        else                chk("order_data", {24'b0, out_data}, {24'b0, mq[0]});
      end
      gap = mq.size() - int'(count);
      chk("count_gap", {31'b0, (gap == 0 || gap == 1)}, 1);
      if (count == 7'd64) chk("full_in_ready", {31'b0, in_ready}, 0);
      if (out_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
      if (in_valid && in_ready) mq.push_back(in_data);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'b0, done}, 1);
  endtask

  initial begin
    int nacc;
    int b;
    int guard;
    bit found;
    logic [7:0] rx [$];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_ram_we", {31'b0, ram_we}, 0);
    chk("rst_count", {25'b0, count}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", {24'b0, out_data}, 0);
    rst = 1'b0;
    #1 chk("idle_in_ready", {31'b0, in_ready}, 1);

    // 1: three back-to-back pushes with a read slotted in after the first
    in_valid = 1'b1; in_data = 8'h11;
    #1 chk("t1_c0_we", {31'b0, ram_we}, 1); chk("t1_c0_addr", {26'b0, ram_addr}, 0);
    tick(); in_data = 8'h22;
    #1 chk("t1_c1_in_ready", {31'b0, in_ready}, 0);
    chk("t1_c1_we", {31'b0, ram_we}, 0); chk("t1_c1_addr", {26'b0, ram_addr}, 0);
    tick();
    #1 chk("t1_c2_we", {31'b0, ram_we}, 1); chk("t1_c2_addr", {26'b0, ram_addr}, 1);
    tick(); in_data = 8'h33;
    #1 chk("t1_c3_out_valid", {31'b0, out_valid}, 1); chk("t1_c3_out_data", {24'b0, out_data}, 8'h11);
    chk("t1_c3_addr", {26'b0, ram_addr}, 2); chk("t1_c3_we", {31'b0, ram_we}, 1);
    tick(); in_valid = 1'b0;
    #1 chk("t1_count", {25'b0, count}, 2); chk("t1_out_data", {24'b0, out_data}, 8'h11);

    // 2: fill to capacity with the output stalled
    do_reset();
    nacc = 0; b = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 8'(b);
      #1;
      if (in_ready) begin b++; nacc++; end
      tick();
    end
    in_valid = 1'b1;
    #1;
    chk("t2_accepted", nacc, 65);
    chk("t2_count", {25'b0, count}, 64);
    chk("t2_in_ready", {31'b0, in_ready}, 0);
    chk("t2_out_valid", {31'b0, out_valid}, 1);
    chk("t2_out_data", {24'b0, out_data}, 8'h00);
    in_valid = 1'b0;

    // 3: 200 bytes streamed through with random upstream gaps (wraps pointers)
    do_reset();
    out_ready = 1'b1; b = 0; guard = 0;
    while (b < 200 && guard < 5000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'(b);
      #1;
      if (out_valid) rx.push_back(out_data);
      if (in_valid && in_ready) b++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (out_valid) rx.push_back(out_data);
      tick();
    end
    chk("t3_rx_len", rx.size(), 200);
    for (int i = 0; i < rx.size() && i < 200; i++) chk("t3_rx_byte", {24'b0, rx[i]}, i);
    #1;
    chk("t3_count", {25'b0, count}, 0);
    chk("t3_out_valid", {31'b0, out_valid}, 0);
    out_ready = 1'b0;

    // 4: write attempt collides with a read issue
    do_reset();
    in_valid = 1'b1; in_data = 8'h77;
    tick(); in_data = 8'h78;
    #1 chk("t4_in_ready", {31'b0, in_ready}, 0);
    chk("t4_we", {31'b0, ram_we}, 0); chk("t4_addr", {26'b0, ram_addr}, 0);
    tick();
    #1 chk("t4_pend_in_ready", {31'b0, in_ready}, 1);
    chk("t4_pend_we", {31'b0, ram_we}, 1); chk("t4_pend_addr", {26'b0, ram_addr}, 1);
    chk("t4_pend_data", {24'b0, ram_data}, 8'h78);
    tick(); in_valid = 1'b0;

    // 5: reset mid-operation discards everything
    do_reset();
    for (int n = 0; n < 11; n++) push(8'(8'h30 + n));
    tick(); tick();
    #1 chk("t5_pre_count", {25'b0, count}, 10);
    chk("t5_pre_out_valid", {31'b0, out_valid}, 1);
    chk("t5_pre_out_data", {24'b0, out_data}, 8'h30);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #1 chk("t5_count", {25'b0, count}, 0);
    chk("t5_out_valid", {31'b0, out_valid}, 0);
    chk("t5_in_ready", {31'b0, in_ready}, 1);
    push(8'hA5);
    out_ready = 1'b1; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (out_valid) found = 1'b1;
      else tick();
    end
    chk("t5_first_seen", {31'b0, found}, 1);
    chk("t5_first_data", {24'b0, out_data}, 8'hA5);
    tick(); out_ready = 1'b0;

    // 6: backpressure holds the output, then one handshake
    do_reset();
    push(8'h5A);
    push(8'h5B);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1 chk("t6_hold_valid", {31'b0, out_valid}, 1);
      chk("t6_hold_data", {24'b0, out_data}, 8'h5A);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t6_hs_data", {24'b0, out_data}, 8'h5A);
    tick(); out_ready = 1'b0;
    #1 chk("t6_after_valid", {31'b0, out_valid}, 0);
    tick();
    #1 chk("t6_next_valid", {31'b0, out_valid}, 1);
    chk("t6_next_data", {24'b0, out_data}, 8'h5B);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
